// File: rtl/md5_pkg.sv
// Shared constants and state type for the MD5 byte-stream padding front end.
package md5_pkg;

  localparam int unsigned MD5_BLOCK_BYTES = 64;
  localparam int unsigned MD5_LEN_OFFSET  = 56;
  localparam logic [7:0]  MD5_PAD_BYTE    = 8'h80;

  typedef enum logic [1:0] {
    StFill,
    StPad,
    StLenBlk,
    StEmit
  } md5_pad_state_t;

endpackage

// File: rtl/md5_pad.sv
// Packs message bytes into 512-bit MD5 blocks and appends 0x80, zero fill and the
// 64-bit little-endian bit length; blocks leave on a valid/ready port.
module md5_pad
  import md5_pkg::*;
#(
  parameter int unsigned LEN_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [511:0] blk_data,
  output logic         blk_valid,
  output logic         blk_first,
  output logic         blk_last,
  input  logic         blk_ready
);

  localparam int unsigned LenLsb = MD5_LEN_OFFSET * 8;

  md5_pad_state_t   state_q, state_d;
  md5_pad_state_t   after_q, after_d;
  logic [511:0]     buf_q, buf_d;
  logic [5:0]       idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             first_pend_q, first_pend_d;
  logic             last_q, last_d;

  always_comb begin
    state_d      = state_q;
    after_d      = after_q;
    buf_d        = buf_q;
    idx_d        = idx_q;
    len_d        = len_q;
    first_pend_d = first_pend_q;
    last_d       = last_q;

    unique case (state_q)
      StFill: begin
        if (in_valid) begin
          buf_d[{idx_q, 3'b000} +: 8] = in_data;
          len_d = len_q + LEN_W'(8);
          idx_d = idx_q + 6'd1;
          if (idx_q == 6'd63) begin
            // A full block goes out first; a final byte here pads into a fresh block.
            state_d = StEmit;
            last_d  = 1'b0;
            after_d = in_last ? StPad : StFill;
          end else if (in_last) begin
            state_d = StPad;
          end
        end
      end

      StPad: begin
        for (int unsigned k = 0; k < MD5_BLOCK_BYTES; k++) begin
          if (k > 32'(idx_q)) buf_d[k*8 +: 8] = 8'h00;
        end
        buf_d[{idx_q, 3'b000} +: 8] = MD5_PAD_BYTE;
        if (idx_q < 6'(MD5_LEN_OFFSET)) begin
          buf_d[LenLsb +: 64] = 64'(len_q);
          last_d  = 1'b1;
          after_d = StFill;
        end else begin
          last_d  = 1'b0;
          after_d = StLenBlk;
        end
        state_d = StEmit;
      end

      StLenBlk: begin
        buf_d               = '0;
        buf_d[LenLsb +: 64] = 64'(len_q);
        last_d              = 1'b1;
        after_d             = StFill;
        state_d             = StEmit;
      end

      StEmit: begin
        if (blk_ready) begin
          buf_d        = '0;
          idx_d        = '0;
          first_pend_d = 1'b0;
          state_d      = after_q;
          if (last_q) begin
            len_d        = '0;
            first_pend_d = 1'b1;
          end
        end
      end

      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StFill;
      after_q      <= StFill;
      buf_q        <= '0;
      idx_q        <= '0;
      len_q        <= '0;
      first_pend_q <= 1'b1;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      after_q      <= after_d;
      buf_q        <= buf_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      first_pend_q <= first_pend_d;
      last_q       <= last_d;
    end
  end

  assign in_ready  = (state_q == StFill) && !rst;
  assign blk_valid = (state_q == StEmit);
  assign blk_data  = buf_q;
  assign blk_first = blk_valid && first_pend_q;
  assign blk_last  = blk_valid && last_q;

endmodule

// File: tb/tb_md5_pad.sv
// Self-checking bench for md5_pad: expected blocks come from a byte-queue padding model.
module tb_md5_pad;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [511:0] data;
    logic         first;
    logic         last;
  } blk_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   in_data = 8'h00;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         in_ready;
  logic [511:0] blk_data;
  logic         blk_valid;
  logic         blk_first;
  logic         blk_last;
  logic         blk_ready = 1'b0;

  int   errors = 0;
  int   checks = 0;
  int   stall  = 0;
  blk_t exp_q[$];

  md5_pad #(.LEN_W(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .blk_data  (blk_data),
    .blk_valid (blk_valid),
    .blk_first (blk_first),
    .blk_last  (blk_last),
    .blk_ready (blk_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Standard MD5 padding on a byte queue, then split into 64-byte blocks.
  task automatic model_msg(input bq_t msg);
    bq_t         p;
    logic [63:0] bits;
    int          nblk;
    blk_t        b;
    p    = msg;
    bits = 64'(msg.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 0; i < 8; i++) p.push_back(bits[8*i +: 8]);
    nblk = p.size() / 64;
    for (int j = 0; j < nblk; j++) begin
      b.data = '0;
      for (int k = 0; k < 64; k++) b.data[8*k +: 8] = p[64*j + k];
      b.first = (j == 0);
      b.last  = (j == nblk - 1);
      exp_q.push_back(b);
    end
  endtask

  // Entered at a negedge with blk_valid high; leaves at a negedge after the handshake.
  task automatic take_block();
    blk_t         e;
    logic [511:0] held;
    if (exp_q.size() == 0) begin
      chk("spurious_blk", blk_valid, 0);
      blk_ready = 1'b1;
      @(negedge clk);
      blk_ready = 1'b0;
      return;
    end
    e = exp_q.pop_front();
    chk("blk_data", blk_data, e.data);
    chk("blk_first", blk_first, e.first);
    chk("blk_last", blk_last, e.last);
    held = blk_data;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("hold_data", blk_data, held);
      chk("hold_valid", blk_valid, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
    if (e.last) chk("ready_after_last", in_ready, 1);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    in_last  = last;
    while (!done) begin
      if (in_ready) begin
        @(negedge clk);
        done = 1'b1;
      end else begin
        if (blk_valid) take_block();
        else @(negedge clk);
        n++;
        if (n > 500) begin
          errors++;
          $display("FAIL send_byte_timeout: in_ready never rose within 500 cycles");
          $fatal(1, "send_byte timeout");
        end
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0) begin
      if (blk_valid) take_block();
      else @(negedge clk);
      n++;
      if (n > 2000) begin
        checks++;
        errors++;
        $error("FAIL drain_timeout: %0d blocks outstanding, required 0", exp_q.size());
        exp_q.delete();
      end
    end
    repeat (3) @(negedge clk);
    chk("no_extra_blk", blk_valid, 0);
  endtask

  task automatic send_msg(input bq_t msg);
    model_msg(msg);
    for (int i = 0; i < msg.size(); i++) begin
      send_byte(msg[i], i == msg.size() - 1);
      if ((i + 1) % 64 == 0) begin
        chk("full_blk_latency", blk_valid, 1);
      end else if (i == msg.size() - 1) begin
        chk("pad_cycle_no_valid", blk_valid, 0);
        @(negedge clk);
        chk("final_blk_latency", blk_valid, 1);
      end
    end
    drain();
  endtask

  function automatic bq_t fill_q(input int n, input logic [7:0] v);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(v);
    return q;
  endfunction

  function automatic bq_t rand_q(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  initial begin
    bq_t abc;
    abc = '{8'h61, 8'h62, 8'h63};

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_blk_valid", blk_valid, 0);
    chk("rst_blk_first", blk_first, 0);
    chk("rst_blk_last", blk_last, 0);
    chk("rst_blk_data", blk_data, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    @(negedge clk);

    // Directed padding cases
    send_msg(abc);
    send_msg(fill_q(55, 8'h00));
    send_msg(fill_q(56, 8'h41));
    send_msg(rand_q(64));

    // Stalled consumer, then back-to-back message restarting length and first flag
    stall = 10;
    send_msg(rand_q(20));
    stall = 0;
    send_msg(rand_q(9));

    // Reset mid-message, then mid-EMIT
    for (int i = 0; i < 30; i++) send_byte(8'($urandom), 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("abort_in_ready", in_ready, 0);
    chk("abort_blk_valid", blk_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 64; i++) send_byte(8'($urandom), 1'b0);
    chk("emit_before_abort", blk_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_emit_valid", blk_valid, 0);
    chk("abort_emit_data", blk_data, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_msg(abc);

    // Randomised messages with random consumer stalls
    for (int r = 0; r < 6; r++) begin
      stall = $urandom_range(0, 3);
      send_msg(rand_q($urandom_range(1, 140)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
